// File: rtl/rsc_pkg.sv
// ----------------------------------------------------------------------------
// rsc_pkg
//   Shared definitions for the RSC instruction interface: field widths,
//   opcode encodings, decoder phase-select (enableRegs) codes, the issue FSM
//   state type, and helpers to pack an instruction word and to classify
//   opcodes that the issue side refuses to forward.
// ----------------------------------------------------------------------------
package rsc_pkg;

  // Instruction word layout: {opcode[15:12], para1[11:6], para2[5:0]}
  localparam int OP_W   = 4;
  localparam int PARA_W = 6;
  localparam int WORD_W = 16;

  typedef logic [OP_W-1:0]   opcode_t;
  typedef logic [PARA_W-1:0] para_t;
  typedef logic [WORD_W-1:0] word_t;

  // Opcode encodings (0, E and F are unassigned)
  localparam opcode_t OP_ADD   = 4'h1;
  localparam opcode_t OP_SUB   = 4'h2;
  localparam opcode_t OP_AND   = 4'h3;
  localparam opcode_t OP_OR    = 4'h4;
  localparam opcode_t OP_XOR   = 4'h5;
  localparam opcode_t OP_NOT   = 4'h6;
  localparam opcode_t OP_SHL   = 4'h7;
  localparam opcode_t OP_SHR   = 4'h8;
  localparam opcode_t OP_MOV   = 4'h9;
  localparam opcode_t OP_CMP   = 4'hA;
  localparam opcode_t OP_MOVI  = 4'hB;
  localparam opcode_t OP_LOAD  = 4'hC;
  localparam opcode_t OP_STORE = 4'hD;

  // Decoder phase select codes
  localparam logic [2:0] ENR_NONE = 3'b000;
  localparam logic [2:0] ENR_LOAD = 3'b100;
  localparam logic [2:0] ENR_P1   = 3'b010;
  localparam logic [2:0] ENR_P2   = 3'b001;

  // Issue FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_PARA1 = 2'd2,
    ST_PARA2 = 2'd3
  } state_e;

  function automatic word_t pack_word(input opcode_t op, input para_t p1, input para_t p2);
    return {op, p1, p2};
  endfunction

  // Opcodes with no defined operation are rejected when opcode checking is built in
  function automatic logic op_legal(input opcode_t op);
    return !(op == 4'h0 || op == 4'hE || op == 4'hF);
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// ----------------------------------------------------------------------------
// instr_fifo
//   Synchronous first-word-fall-through FIFO holding packed instruction words.
//   DEPTH must be a power of two so the pointers wrap naturally.
// Ports
//   clk    in   clock, posedge
//   rst    in   synchronous active-low reset (empties the queue)
//   push   in   write din (ignored when full)
//   din    in   WIDTH-bit data to store
//   pop    in   drop the head entry (ignored when empty)
//   dout   out  head entry, valid whenever empty=0
//   full   out  count == DEPTH
//   empty  out  count == 0
//   count  out  number of stored entries
// ----------------------------------------------------------------------------
module instr_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge value of the others; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the count/pointers alone decide
  // what is valid, and leaving the array reset-free lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/instr_enc.sv
// ----------------------------------------------------------------------------
// instr_enc
//   Issue side of the RSC instruction interface. Queues {opcode, para1, para2}
//   requests, packs each into a 16-bit word and sequences the shared bus and
//   decoder phase selects: LOAD (word driven), PARA1, PARA2 (decoder owns the
//   bus). Each phase lasts HOLD_CYCLES clocks; back-to-back instructions run
//   with no idle gap.
// Build option
//   INSTR_ENC_OPCHECK_EN : opcodes 0, E, F are handshaken but not queued, and
//                          errOut pulses the cycle after the accepting edge.
//                          Undefined: every opcode is queued, errOut is 0.
// Ports
//   clk         in   clock, posedge
//   rst         in   synchronous active-low reset
//   inValid     in   request valid
//   inReady     out  queue can accept (rst && !full)
//   inOpCode    in   4-bit opcode
//   inPara1     in   6-bit first operand
//   inPara2     in   6-bit second operand / immediate
//   busDataOut  out  instruction word during LOAD, else 0
//   busDrive    out  bus output enable (LOAD only)
//   enableRegs  out  decoder phase select 000/100/010/001
//   busy        out  FSM not idle or queue not empty
//   issued      out  pulse on last cycle of PARA2
//   errOut      out  pulse on rejected request
// ----------------------------------------------------------------------------
module instr_enc
  import rsc_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inValid,
  output logic              inReady,
  input  logic [OP_W-1:0]   inOpCode,
  input  logic [PARA_W-1:0] inPara1,
  input  logic [PARA_W-1:0] inPara2,
  output logic [WORD_W-1:0] busDataOut,
  output logic              busDrive,
  output logic [2:0]        enableRegs,
  output logic              busy,
  output logic              issued,
  output logic              errOut
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_e            state;
  state_e            state_n;
  logic [CNT_W-1:0]  phase_cnt;
  logic              phase_done;
  word_t             word;

  logic              fifo_push;
  logic              fifo_pop;
  word_t             fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [AW:0]       fifo_count;
  logic              accept;

  // ------------------------------------------------------------------------
  // Request side
  // ------------------------------------------------------------------------
  assign inReady = rst && !fifo_full;
  assign accept  = inValid && inReady;

`ifdef INSTR_ENC_OPCHECK_EN
  logic err_q;

  // Rejected opcodes still complete the handshake; they just never reach the queue.
  assign fifo_push = accept && op_legal(inOpCode);

  always_ff @(posedge clk) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= accept && !op_legal(inOpCode);
  end

  assign errOut = err_q;
`else
  assign fifo_push = accept;
  assign errOut    = 1'b0;
`endif

  instr_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (pack_word(inOpCode, inPara1, inPara2)),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ------------------------------------------------------------------------
  // Issue FSM
  // ------------------------------------------------------------------------
  assign phase_done = (phase_cnt == CNT_W'(HOLD_CYCLES - 1));

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_n  = state;
    fifo_pop = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_n  = ST_LOAD;
          fifo_pop = 1'b1;
        end
      end
      ST_LOAD: begin
        if (phase_done) state_n = ST_PARA1;
      end
      ST_PARA1: begin
        if (phase_done) state_n = ST_PARA2;
      end
      ST_PARA2: begin
        if (phase_done) begin
          if (!fifo_empty) begin
            state_n  = ST_LOAD;
            fifo_pop = 1'b1;
          end else begin
            state_n  = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      phase_cnt <= '0;
      word      <= '0;
    end else begin
      state <= state_n;
      // Restart the hold count on any phase change, including PARA2 -> LOAD.
      if (state_n != state || state == ST_IDLE) phase_cnt <= '0;
      else                                      phase_cnt <= phase_cnt + CNT_W'(1);
      if (fifo_pop) word <= fifo_dout;
    end
  end

  // ------------------------------------------------------------------------
  // Outputs decoded from the registered state
  // ------------------------------------------------------------------------
  always_comb begin
    enableRegs = ENR_NONE;
    busDrive   = 1'b0;
    case (state)
      ST_LOAD:  begin enableRegs = ENR_LOAD; busDrive = 1'b1; end
      ST_PARA1: enableRegs = ENR_P1;
      ST_PARA2: enableRegs = ENR_P2;
      default:  enableRegs = ENR_NONE;
    endcase
  end

  assign busDataOut = busDrive ? word : '0;
  // Gated by rst so a reset landing on the final PARA2 cycle never reports completion.
  assign issued     = rst && (state == ST_PARA2) && phase_done;
  assign busy       = (state != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_instr_enc.sv
// ----------------------------------------------------------------------------
// tb_instr_enc
//   Directed self-checking bench for instr_enc. "dut" runs with HOLD_CYCLES=1,
//   "dut2" with HOLD_CYCLES=2; both share clk and rst.
// ----------------------------------------------------------------------------
module tb_instr_enc;

  logic        clk = 1'b0;
  logic        rst;

  logic        inValid, inReady;
  logic [3:0]  inOpCode;
  logic [5:0]  inPara1, inPara2;
  logic [15:0] busDataOut;
  logic        busDrive, busy, issued, errOut;
  logic [2:0]  enableRegs;

  logic        in2Valid, in2Ready;
  logic [3:0]  in2OpCode;
  logic [5:0]  in2Para1, in2Para2;
  logic [15:0] bus2DataOut;
  logic        bus2Drive, busy2, issued2, err2Out;
  logic [2:0]  enable2Regs;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [15:0] loads[$];
  int          load_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  instr_enc #(.FIFO_DEPTH(4), .HOLD_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .inValid(inValid), .inReady(inReady),
    .inOpCode(inOpCode), .inPara1(inPara1), .inPara2(inPara2),
    .busDataOut(busDataOut), .busDrive(busDrive), .enableRegs(enableRegs),
    .busy(busy), .issued(issued), .errOut(errOut)
  );

  instr_enc #(.FIFO_DEPTH(4), .HOLD_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst),
    .inValid(in2Valid), .inReady(in2Ready),
    .inOpCode(in2OpCode), .inPara1(in2Para1), .inPara2(in2Para2),
    .busDataOut(bus2DataOut), .busDrive(bus2Drive), .enableRegs(enable2Regs),
    .busy(busy2), .issued(issued2), .errOut(err2Out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample #1 after the edge, and log every LOAD cycle of dut.
  task automatic tick();
    @(posedge clk);
    #1;
    if (enableRegs === 3'b100) begin
      loads.push_back(busDataOut);
      load_cyc.push_back(cyc);
    end
  endtask

  task automatic set_in(input logic v, input logic [3:0] op, input logic [5:0] p1, input logic [5:0] p2);
    inValid  = v;
    inOpCode = op;
    inPara1  = p1;
    inPara2  = p2;
  endtask

  function automatic logic [15:0] pk(input logic [3:0] op, input logic [5:0] p1, input logic [5:0] p2);
    return {op, p1, p2};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w3 [6];
    logic [15:0] wa, wb, wc, wd;
    int  idx;
    int  first_push;
    bit  acc;
    bit  saw_full;

    rst = 1'b0;
    set_in(1'b0, 4'h0, 6'h0, 6'h0);
    in2Valid = 1'b0; in2OpCode = 4'h0; in2Para1 = 6'h0; in2Para2 = 6'h0;
    tick(); tick();

    // ---------------- reset state ----------------
    check("rst_inReady", inReady, 0);
    check("rst_en", enableRegs, 3'b000);
    check("rst_drive", busDrive, 0);
    check("rst_data", busDataOut, 16'h0000);
    check("rst_busy", busy, 0);
    check("rst_issued", issued, 0);
    check("rst_err", errOut, 0);
    rst = 1'b1;
    #1;
    check("rel_inReady", inReady, 1);

    // ---------------- 1: single ADD, HOLD=1 ----------------
    set_in(1'b1, 4'h1, 6'd3, 6'd5);
    tick();
    set_in(1'b0, 4'h0, 6'h0, 6'h0);
    check("t1_busy_queued", busy, 1);
    check("t1_idle_before_load", enableRegs, 3'b000);
    tick();
    check("t1_load_data", busDataOut, 16'h10C5);
    check("t1_load_drive", busDrive, 1);
    check("t1_load_en", enableRegs, 3'b100);
    check("t1_load_issued", issued, 0);
    tick();
    check("t1_p1_en", enableRegs, 3'b010);
    check("t1_p1_drive", busDrive, 0);
    check("t1_p1_data", busDataOut, 16'h0000);
    tick();
    check("t1_p2_en", enableRegs, 3'b001);
    check("t1_p2_issued", issued, 1);
    tick();
    check("t1_idle_en", enableRegs, 3'b000);
    check("t1_idle_issued", issued, 0);
    check("t1_idle_busy", busy, 0);

    // ---------------- 2: reset during PARA1 ----------------
    set_in(1'b1, 4'h2, 6'd1, 6'd1);
    tick();
    set_in(1'b0, 4'h0, 6'h0, 6'h0);
    tick();
    check("t2_load_data", busDataOut, 16'h2041);
    tick();
    check("t2_p1_en", enableRegs, 3'b010);
    rst = 1'b0;
    #1;
    check("t2_inReady_in_rst", inReady, 0);
    tick();
    check("t2_after_rst_en", enableRegs, 3'b000);
    check("t2_after_rst_drive", busDrive, 0);
    check("t2_after_rst_busy", busy, 0);
    check("t2_after_rst_issued", issued, 0);
    rst = 1'b1;
    #1;
    check("t2_inReady_release", inReady, 1);
    tick();
    check("t2_stays_idle", enableRegs, 3'b000);
    check("t2_no_issued", issued, 0);

    // ---------------- 3: six words with inValid held ----------------
    for (int i = 0; i < 6; i++)
      w3[i] = pk(4'(i + 1), 6'(i + 10), 6'(i + 40));
    loads.delete();
    load_cyc.delete();
    idx = 0;
    first_push = -1;
    saw_full = 1'b0;
    for (int c = 0; c < 60 && loads.size() < 6; c++) begin
      if (idx < 6) set_in(1'b1, 4'(idx + 1), 6'(idx + 10), 6'(idx + 40));
      else         inValid = 1'b0;
      acc = inValid && inReady;
      tick();
      if (acc) begin
        if (first_push < 0) first_push = cyc;
        idx++;
      end
      if (idx == 6 && !saw_full) begin
        saw_full = 1'b1;
        inValid  = 1'b0;
        check("t3_count_full", dut.u_fifo.count, 4);
        check("t3_inReady_full", inReady, 0);
      end
    end
    check("t3_pushes", idx, 6);
    check("t3_loads", loads.size(), 6);
    check("t3_latency", load_cyc[0] - first_push, 1);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("t3_word%0d", k), loads[k], w3[k]);
      if (k > 0) check($sformatf("t3_gap%0d", k), load_cyc[k] - load_cyc[k-1], 3);
    end
    tick(); tick(); tick();
    check("t3_idle_en", enableRegs, 3'b000);
    check("t3_idle_busy", busy, 0);

    // ---------------- 4: MOVI on HOLD_CYCLES=2 ----------------
    in2Valid = 1'b1; in2OpCode = 4'hB; in2Para1 = 6'd2; in2Para2 = 6'd63;
    tick();
    in2Valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      check($sformatf("t4_data_c%0d", c), bus2DataOut, (c <= 2) ? 16'hB0BF : 16'h0000);
      check($sformatf("t4_en_c%0d", c), enable2Regs,
            (c <= 2) ? 3'b100 : (c <= 4) ? 3'b010 : 3'b001);
      check($sformatf("t4_issued_c%0d", c), issued2, (c == 6) ? 1 : 0);
    end
    tick();
    check("t4_idle_en", enable2Regs, 3'b000);
    check("t4_idle_busy", busy2, 0);

    // ---------------- 5: illegal opcode F followed by MOVI ----------------
    loads.delete();
    load_cyc.delete();
    set_in(1'b1, 4'hF, 6'd0, 6'd0);
    #1;
    check("t5_ready_bad_op", inReady, 1);
    tick();
`ifdef INSTR_ENC_OPCHECK_EN
    check("t5_err_pulse", errOut, 1);
`else
    check("t5_err_pulse", errOut, 0);
`endif
    set_in(1'b1, 4'hB, 6'd2, 6'd63);
    tick();
    set_in(1'b0, 4'h0, 6'h0, 6'h0);
    check("t5_err_clear", errOut, 0);
    repeat (10) tick();
`ifdef INSTR_ENC_OPCHECK_EN
    check("t5_loads", loads.size(), 1);
    check("t5_word0", loads[0], 16'hB0BF);
`else
    check("t5_loads", loads.size(), 2);
    check("t5_word0", loads[0], 16'hF000);
    check("t5_word1", loads[1], 16'hB0BF);
`endif
    check("t5_idle_busy", busy, 0);

    // ---------------- 6: push while popping at count=2 ----------------
    loads.delete();
    load_cyc.delete();
    wa = pk(4'h1, 6'd1, 6'd1);
    wb = pk(4'h2, 6'd2, 6'd2);
    wc = pk(4'h3, 6'd3, 6'd3);
    wd = pk(4'h4, 6'd4, 6'd4);
    set_in(1'b1, 4'h1, 6'd1, 6'd1);
    tick();
    set_in(1'b1, 4'h2, 6'd2, 6'd2);
    tick();
    set_in(1'b1, 4'h3, 6'd3, 6'd3);
    tick();
    inValid = 1'b0;
    check("t6_count_before", dut.u_fifo.count, 2);
    tick();
    check("t6_in_para2", enableRegs, 3'b001);
    set_in(1'b1, 4'h4, 6'd4, 6'd4);
    tick();
    inValid = 1'b0;
    check("t6_count_same", dut.u_fifo.count, 2);
    check("t6_popped_word", busDataOut, wb);
    check("t6_load_en", enableRegs, 3'b100);
    repeat (12) tick();
    check("t6_loads", loads.size(), 4);
    check("t6_word0", loads[0], wa);
    check("t6_word1", loads[1], wb);
    check("t6_word2", loads[2], wc);
    check("t6_word3", loads[3], wd);
    check("t6_idle_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
